// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time config sequencer: freezes, numbers and points every core tile at the boot PC, then unfreezes all tiles.
// Optional macro BP_CFG_BOOT_SEQ_ICACHE_CLEAR_EN inserts an ICACHE_CLR write between CORE_ID and NPC for each tile.
module bp_cfg_boot_sequencer #(
    parameter int                       num_core_p       = 1,
    parameter int                       cfg_addr_width_p = 16,
    parameter int                       cfg_data_width_p = 64,
    parameter int                       vaddr_width_p    = 39,
    parameter logic [vaddr_width_p-1:0] boot_pc_p        = 39'h00_8000_0000,
    parameter int                       max_credits_p    = 8,
    localparam int                      tile_width_lp    = (num_core_p > 1) ? $clog2(num_core_p) : 1,
    localparam int                      cred_width_lp    = $clog2(max_credits_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [tile_width_lp-1:0]    cfg_tile_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_resp_v_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp  = cfg_addr_width_p'(16'h0001);
    localparam logic [cfg_addr_width_p-1:0] addr_core_id_lp = cfg_addr_width_p'(16'h0002);
    localparam logic [cfg_addr_width_p-1:0] addr_npc_lp     = cfg_addr_width_p'(16'h0010);
`ifdef BP_CFG_BOOT_SEQ_ICACHE_CLEAR_EN
    localparam logic [cfg_addr_width_p-1:0] addr_icache_lp  = cfg_addr_width_p'(16'h0020);
`endif
    localparam logic [tile_width_lp-1:0]    last_tile_lp    = tile_width_lp'(num_core_p - 1);
    localparam logic [cred_width_lp-1:0]    max_cred_lp     = cred_width_lp'(max_credits_p);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FREEZE,
        ST_CORE_ID,
`ifdef BP_CFG_BOOT_SEQ_ICACHE_CLEAR_EN
        ST_ICACHE_CLR,
`endif
        ST_NPC,
        ST_DRAIN,
        ST_UNFREEZE,
        ST_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [tile_width_lp-1:0]    tile_q, tile_d;
    logic [cred_width_lp-1:0]    credits_q, credits_d;
    logic                        cfg_v_q, cfg_v_d;
    logic [cfg_addr_width_p-1:0] addr_q, addr_d;
    logic [cfg_data_width_p-1:0] data_q, data_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;
    logic                        hs;

    always_comb begin
        state_d   = state_q;
        tile_d    = tile_q;
        credits_d = credits_q;
        cfg_v_d   = cfg_v_q;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        hs        = cfg_v_q && cfg_ready_i;

        // A response with nothing outstanding is dropped and flagged; sequencing carries on.
        if (hs && !cfg_resp_v_i) begin
            credits_d = credits_q + cred_width_lp'(1);
        end else if (!hs && cfg_resp_v_i) begin
            if (credits_q == '0) err_d = 1'b1;
            else                 credits_d = credits_q - cred_width_lp'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FREEZE;
                    tile_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_FREEZE:  if (hs) state_d = ST_CORE_ID;
`ifdef BP_CFG_BOOT_SEQ_ICACHE_CLEAR_EN
            ST_CORE_ID:    if (hs) state_d = ST_ICACHE_CLR;
            ST_ICACHE_CLR: if (hs) state_d = ST_NPC;
`else
            ST_CORE_ID:    if (hs) state_d = ST_NPC;
`endif
            ST_NPC: begin
                if (hs) begin
                    if (tile_q == last_tile_lp) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FREEZE;
                        tile_d  = tile_q + tile_width_lp'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (credits_q == '0) begin
                    state_d = ST_UNFREEZE;
                    tile_d  = '0;
                end
            end
            ST_UNFREEZE: begin
                if (hs) begin
                    if (tile_q == last_tile_lp) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        tile_d = tile_q + tile_width_lp'(1);
                    end
                end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        // A presented write is frozen until accepted; otherwise re-derive it from the next state.
        if (!(cfg_v_q && !cfg_ready_i)) begin
            cfg_v_d = 1'b0;
            addr_d  = '0;
            data_d  = '0;
            case (state_d)
                ST_FREEZE: begin
                    cfg_v_d = (credits_d < max_cred_lp);
                    addr_d  = addr_freeze_lp;
                    data_d  = cfg_data_width_p'(1'b1);
                end
                ST_CORE_ID: begin
                    cfg_v_d = (credits_d < max_cred_lp);
                    addr_d  = addr_core_id_lp;
                    data_d  = cfg_data_width_p'(tile_d);
                end
`ifdef BP_CFG_BOOT_SEQ_ICACHE_CLEAR_EN
                ST_ICACHE_CLR: begin
                    cfg_v_d = (credits_d < max_cred_lp);
                    addr_d  = addr_icache_lp;
                    data_d  = cfg_data_width_p'(1'b1);
                end
`endif
                ST_NPC: begin
                    cfg_v_d = (credits_d < max_cred_lp);
                    addr_d  = addr_npc_lp;
                    data_d  = cfg_data_width_p'(boot_pc_p);
                end
                ST_UNFREEZE: begin
                    cfg_v_d = (credits_d < max_cred_lp);
                    addr_d  = addr_freeze_lp;
                    data_d  = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            tile_q    <= '0;
            credits_q <= '0;
            cfg_v_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tile_q    <= tile_d;
            credits_q <= credits_d;
            cfg_v_q   <= cfg_v_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cfg_v_o    = cfg_v_q;
    assign cfg_tile_o = tile_q;
    assign cfg_addr_o = addr_q;
    assign cfg_data_o = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
